// File: rtl/mulint_run_param_if.sv
// mulint_run_param_if: run handshake, operands and formatted result of the multiplier method
interface mulint_run_param_if #(
  parameter int WIDTH = 32
);
  logic             i_run_req;
  logic             o_run_busy;
  logic             o_run_done;
  logic [WIDTH-1:0] o_run_return;
  logic             o_run_overflow;
  logic [WIDTH-1:0] i_run_input_a;
  logic [WIDTH-1:0] i_run_input_b;
  logic [1:0]       i_run_mode;
  modport slave (
    input  i_run_req, i_run_input_a, i_run_input_b, i_run_mode,
    output o_run_busy, o_run_done, o_run_return, o_run_overflow
  );
  modport master (
    output i_run_req, i_run_input_a, i_run_input_b, i_run_mode,
    input  o_run_busy, o_run_done, o_run_return, o_run_overflow
  );
endinterface

// File: rtl/mulint_run_param.sv
// mulint_run_param: run-wrapped pipelined WIDTH x WIDTH multiplier with runtime result formatting
module mulint_run_param #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  mulint_run_param_if.slave run
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FMT} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_a, r_b, r_ret, w_ret;
  logic [1:0]        r_mode;
  logic              r_busy, r_done, r_ov, w_ov, w_last, w_fit, w_sgn;
  logic signed [PW-1:0] w_ea, w_eb;
  logic [PW-1:0]     w_prod, w_p;
  logic [PW-1:0]     r_pipe [LATENCY];
  assign w_last = r_cnt == CW'(LATENCY - 1);
  // operands extended to full product width so the most negative square is exact
  assign w_sgn  = r_mode != 2'b01;
  assign w_ea   = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_eb   = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ea * w_eb;
  assign w_p    = r_pipe[LATENCY-1];
  assign w_fit  = &w_p[PW-1:WIDTH-1] | ~|w_p[PW-1:WIDTH-1];
  assign run.o_run_busy     = r_busy;
  assign run.o_run_done     = r_done;
  assign run.o_run_return   = r_ret;
  assign run.o_run_overflow = r_ov;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run.i_run_req) w_next = S_MUL;
      S_MUL:   if (w_last) w_next = S_FMT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_ret = w_p[WIDTH-1:0];
    w_ov  = 1'b0;
    case (r_mode)
      2'b00: w_ov = ~w_fit;
      2'b01: w_ov = |w_p[PW-1:WIDTH];
      2'b10: w_ret = w_p[PW-1:WIDTH];
      default: begin
        w_ret = w_fit ? w_p[WIDTH-1:0] : {w_p[PW-1], {(WIDTH-1){~w_p[PW-1]}}};
        w_ov  = ~w_fit;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else if (ce) r_state <= w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (ce) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ret  <= '0;
      r_ov   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= 2'b00;
    end else if (ce) begin
      r_done <= r_state == S_FMT;
      if (r_state == S_IDLE && run.i_run_req) begin
        r_a    <= run.i_run_input_a;
        r_b    <= run.i_run_input_b;
        r_mode <= run.i_run_mode;
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end
      if (r_state == S_MUL) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_FMT) begin
        r_ret  <= w_ret;
        r_ov   <= w_ov;
        r_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mulint_run_param.sv
// tb_mulint_run_param: directed and random runs checked against an arithmetic reference model
module tb_mulint_run_param;
  localparam int W = 32;
  localparam int L = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ce    = 1'b1;
  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] last_ret = '0;
  logic         last_ov  = 1'b0;
  mulint_run_param_if #(.WIDTH(W)) run ();
  mulint_run_param #(.WIDTH(W), .LATENCY(L)) dut (.clock(clock), .reset(reset), .ce(ce), .run(run));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                output logic [31:0] r, output logic o);
    longint sa, sb, sp, mx, mn;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    up = ua * ub;
    mx = 64'sd2147483647;
    mn = -64'sd2147483648;
    case (m)
      2'd0: begin r = sp[31:0]; o = (sp > mx) || (sp < mn); end
      2'd1: begin r = up[31:0]; o = up > 64'h0000_0000_FFFF_FFFF; end
      2'd2: begin r = sp[63:32]; o = 1'b0; end
      default: begin
        r = sp > mx ? mx[31:0] : sp < mn ? mn[31:0] : sp[31:0];
        o = (sp > mx) || (sp < mn);
      end
    endcase
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input bit hold, input bit scramble, input int stall_k, input string tag);
    logic [31:0] er;
    logic        eo;
    model(a, b, m, er, eo);
    @(negedge clock);
    run.i_run_req = 1'b1; run.i_run_input_a = a; run.i_run_input_b = b; run.i_run_mode = m;
    @(posedge clock); #1;
    check({tag, " accept busy"}, 64'(run.o_run_busy), 64'd1);
    check({tag, " accept done"}, 64'(run.o_run_done), 64'd0);
    check({tag, " held return"}, 64'(run.o_run_return), 64'(last_ret));
    check({tag, " held ovf"}, 64'(run.o_run_overflow), 64'(last_ov));
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clock);
      run.i_run_req = hold;
      if (scramble) begin
        run.i_run_input_a = $urandom; run.i_run_input_b = $urandom; run.i_run_mode = 2'($urandom);
      end
      if (k == stall_k) begin
        ce = 1'b0;
        repeat (3) begin
          @(posedge clock); #1;
          check({tag, " stall busy"}, 64'(run.o_run_busy), 64'd1);
          check({tag, " stall done"}, 64'(run.o_run_done), 64'd0);
        end
        @(negedge clock);
        ce = 1'b1;
      end
      @(posedge clock); #1;
      if (k <= L) begin
        check({tag, " mul busy"}, 64'(run.o_run_busy), 64'd1);
        check({tag, " mul done"}, 64'(run.o_run_done), 64'd0);
      end else begin
        check({tag, " end busy"}, 64'(run.o_run_busy), 64'd0);
        check({tag, " end done"}, 64'(run.o_run_done), 64'd1);
        check({tag, " return"}, 64'(run.o_run_return), 64'(er));
        check({tag, " overflow"}, 64'(run.o_run_overflow), 64'(eo));
      end
    end
    last_ret = er;
    last_ov  = eo;
  endtask

  initial begin
    run.i_run_req = 1'b0; run.i_run_input_a = '0; run.i_run_input_b = '0; run.i_run_mode = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 64'(run.o_run_busy), 64'd0);
    check("reset done", 64'(run.o_run_done), 64'd0);
    check("reset return", 64'(run.o_run_return), 64'd0);
    check("reset ovf", 64'(run.o_run_overflow), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op(32'd7, 32'd6, 2'b00, 1'b0, 1'b0, 0, "basic");
    @(posedge clock); #1;
    check("basic done drop", 64'(run.o_run_done), 64'd0);
    run_op(-32'sd3, 32'd5, 2'b00, 1'b0, 1'b0, 0, "neg low");
    run_op(32'h4000_0000, 32'd8, 2'b10, 1'b0, 1'b0, 0, "high");
    run_op(32'hFFFF_FFFF, 32'd1, 2'b10, 1'b0, 1'b0, 0, "neg high");
    run_op(32'hFFFF_FFFF, 32'd2, 2'b01, 1'b0, 1'b0, 0, "unsigned");
    run_op(32'h7FFF_FFFF, 32'd2, 2'b11, 1'b0, 1'b0, 0, "sat pos");
    run_op(32'h8000_0000, 32'h8000_0000, 2'b11, 1'b0, 1'b0, 0, "sat minsq");
    run_op(32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 1'b0, 0, "minsq low");
    run_op(32'h8000_0000, 32'd2, 2'b11, 1'b0, 1'b0, 0, "sat neg");
    run_op(32'h8000_0000, 32'd1, 2'b11, 1'b0, 1'b0, 0, "sat edge");
    run_op(32'd7, 32'd6, 2'b00, 1'b0, 1'b1, 3, "ce stall");
    // freeze while the done pulse is up
    @(negedge clock);
    ce = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("frozen done", 64'(run.o_run_done), 64'd1);
      check("frozen return", 64'(run.o_run_return), 64'(last_ret));
    end
    @(negedge clock);
    ce = 1'b1;
    @(posedge clock); #1;
    check("unfrozen done", 64'(run.o_run_done), 64'd0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 1'b1, 1'b1, 0, "b2b 1");
    run_op(32'hFFFF_0001, 32'h0000_FFFF, 2'b01, 1'b1, 1'b1, 0, "b2b 2");
    run_op(32'h8000_0001, 32'h7FFF_FFFF, 2'b10, 1'b1, 1'b1, 0, "b2b 3");
    @(negedge clock);
    run.i_run_req = 1'b0;
    @(posedge clock); #1;
    check("b2b idle busy", 64'(run.o_run_busy), 64'd0);
    check("b2b idle return", 64'(run.o_run_return), 64'(last_ret));
    // abort a run in its third cycle
    @(negedge clock);
    run.i_run_req = 1'b1; run.i_run_input_a = 32'd100; run.i_run_input_b = 32'd3; run.i_run_mode = 2'b00;
    @(posedge clock);
    @(negedge clock);
    run.i_run_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort busy", 64'(run.o_run_busy), 64'd0);
    check("abort done", 64'(run.o_run_done), 64'd0);
    check("abort return", 64'(run.o_run_return), 64'd0);
    check("abort ovf", 64'(run.o_run_overflow), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < L + 3; i++) begin
      @(posedge clock); #1;
      check("post abort done", 64'(run.o_run_done), 64'd0);
    end
    last_ret = '0;
    last_ov  = 1'b0;
    run_op(32'd11, 32'd13, 2'b00, 1'b0, 1'b0, 0, "fresh");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(ra, rb, 2'($urandom), 1'($urandom), 1'b1, (i % 5 == 0) ? int'($urandom_range(1, L + 1)) : 0, "random");
    end
    @(negedge clock);
    run.i_run_req = 1'b0;
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
